gate_truth_table_checker: RTL and testbench

// - Self-contained response checker for the 2-input and/or/not gate block: drives a,b through all

---
 rtl/gate_chk_pkg.sv | 28 ++
 rtl/gate_truth_table_checker_hold_timer.sv | 41 ++++
 rtl/gate_truth_table_checker.sv | 129 ++++++++++++
 tb/tb_gate_truth_table_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker.
//   - state_e : checker FSM states
//   - VEC_W   : width of the {a,b} input vector
//   - OUT_W   : width of the gate output bus c
//   - N_VEC   : number of vectors in a sweep (always 4)
//   - TMR_W   : width of the hold down-counter
//   - exp_out : expected c for a given {a,b} vector
package gate_chk_pkg;

  localparam int VEC_W = 2;
  localparam int OUT_W = 3;
  localparam int N_VEC = 4;
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_HOLD,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // c[0] = a & b, c[1] = a | b, c[2] = ~a, with v[1] driving a and v[0] driving b.
  function automatic logic [OUT_W-1:0] exp_out(input logic [VEC_W-1:0] v);
    return {~v[1], v[1] | v[0], v[1] & v[0]};
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_hold_timer.sv
// Loadable 8-bit down-counter that times how long each vector is held.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (count -> 0)
//   load_i  : load value_i into the counter this cycle
//   value_i : load value
//   zero_o  : counter is at zero
// The count stops at zero rather than wrapping, so zero_o stays asserted
// until the next load.
module hold_timer
  import gate_chk_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] value_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Response checker for the 2-input and/or/not gate block. On start it walks
// {a,b} through 0..3, holds each vector HOLD_CYCLES cycles, samples c once
// and compares it against the expected truth table.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   start_i     : one-cycle sweep request, honoured in IDLE and DONE only
//   a_o, b_o    : gate inputs driven to the block under test
//   c_i         : gate outputs {~a, a|b, a&b}
//   busy_o      : sweep in progress
//   done_o      : sweep finished, results valid
//   pass_o      : done and no mismatches
//   err_count_o : number of mismatching vectors (0..4)
//   fail_mask_o : bit i set if vector {a,b}=i mismatched
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | waiting for start, outputs at reset values
// ST_APPLY  | drive {a,b}=index, load the hold timer
// ST_HOLD   | let c settle; c is ignored here
// ST_SAMPLE | compare c with the expected value, advance
// ST_DONE   | results valid, last vector still driven
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             a_o,
  output logic             b_o,
  input  logic [OUT_W-1:0] c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [2:0]       err_count_o,
  output logic [N_VEC-1:0] fail_mask_o
);

  localparam logic [VEC_W-1:0] LAST_IDX  = VEC_W'(N_VEC - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q,   idx_d;
  logic [VEC_W-1:0] ab_q,    ab_d;
  logic [2:0]       err_q,   err_d;
  logic [N_VEC-1:0] mask_q,  mask_d;
  logic             tmr_load;
  logic             tmr_zero;
  logic             mismatch;

  hold_timer u_hold_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load),
    .value_i (HOLD_LOAD),
    .zero_o  (tmr_zero)
  );

  // Case inequality so an X/Z on c counts as a mismatch in simulation.
  assign mismatch = (c_i !== exp_out(idx_q));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ab_d     = ab_q;
    err_d    = err_q;
    mask_d   = mask_q;
    tmr_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_APPLY;
          idx_d   = '0;
          err_d   = '0;
          mask_d  = '0;
        end
      end
      ST_APPLY: begin
        ab_d     = idx_q;
        tmr_load = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d         = err_q + 3'd1;
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ab_q    <= '0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign a_o         = ab_q[1];
  assign b_o         = ab_q[0];
  assign busy_o      = (state_q == ST_APPLY) || (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = done_o && (err_q == '0);
  assign err_count_o = err_q;
  assign fail_mask_o = mask_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       a, b, a1, b1;
  logic [2:0] c, c1;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [2:0] err, err1;
  logic [3:0] fmask, fmask1;

  int         checks = 0;
  int         errors = 0;
  int         fault_mode = 0;
  logic [2:0] xorv [4];
  logic       glitch1 = 1'b0;

  always #5 clk = ~clk;

  gate_truth_table_checker #(.HOLD_CYCLES(20)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_o(a), .b_o(b), .c_i(c),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err), .fail_mask_o(fmask)
  );

  gate_truth_table_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .a_o(a1), .b_o(b1), .c_i(c1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1), .fail_mask_o(fmask1)
  );

  // Gate block models: 0 good, 1 AND replaced by OR, 2 stuck at 000, 3 random corruption.
  function automatic logic [2:0] gate_model(input int mode, input logic x, input logic y,
                                            input logic [2:0] xv);
    logic [2:0] g;
    g = {~x, x | y, x & y};
    case (mode)
      1:       return {~x, x | y, x | y};
      2:       return 3'b000;
      3:       return g ^ xv;
      default: return g;
    endcase
  endfunction

  always_comb c  = gate_model(fault_mode, a, b, xorv[{a, b}]);
  always_comb c1 = glitch1 ? ~{~a1, a1 | b1, a1 & b1} : {~a1, a1 | b1, a1 & b1};

  // Reference: truth table from arithmetic, judged against what the modelled gate emits.
  task automatic ref_sweep(input int mode, output logic [2:0] e_err, output logic [3:0] e_mask);
    int x, y, exp_v, got_v;
    e_err = 0;
    e_mask = 0;
    for (int i = 0; i < 4; i++) begin
      x = i / 2;
      y = i % 2;
      exp_v = (1 - x) * 4 + ((x + y > 0) ? 2 : 0) + x * y;
      got_v = int'(gate_model(mode, x[0], y[0], xorv[i]));
      if (got_v != exp_v) begin
        e_err = e_err + 3'd1;
        e_mask[i] = 1'b1;
      end
    end
  endtask

  task automatic run0(input int poke, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (poke > 0 && cyc == poke);
    end
    start = 1'b0;
  endtask

  task automatic run1(input logic [3:0] m, output int cyc);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    glitch1 = 1'b0;
    while (!done1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      // After k edges we are in cycle k+1: phase 0 APPLY, 1 HOLD, 2 SAMPLE of vector k/3.
      glitch1 = (cyc < 12) && ((cyc % 3 == 1) || (cyc % 3 == 2 && m[cyc/3]));
    end
    glitch1 = 1'b0;
  endtask

  task automatic check_result(input string name, input int cyc, input int exp_cyc,
                              input logic [2:0] e_err, input logic [3:0] e_mask);
    checks++;
    if (cyc !== exp_cyc) begin errors++; $display("FAIL %s len: got %0d expected %0d", name, cyc, exp_cyc); end
    checks++;
    if (err !== e_err) begin errors++; $display("FAIL %s err_count: got %0d expected %0d", name, err, e_err); end
    checks++;
    if (fmask !== e_mask) begin errors++; $display("FAIL %s fail_mask: got %b expected %b", name, fmask, e_mask); end
    checks++;
    if (pass !== (e_err == 0)) begin errors++; $display("FAIL %s pass: got %b expected %b", name, pass, e_err == 0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; fault_mode = 0;
    for (int i = 0; i < 4; i++) xorv[i] = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({a, b, busy, done, pass} !== 5'b0) begin errors++; $display("FAIL reset ctl: got %b expected 00000", {a, b, busy, done, pass}); end
    checks++;
    if ({err, fmask} !== 7'b0) begin errors++; $display("FAIL reset results: got %b expected 0000000", {err, fmask}); end
    checks++;
    if ({a1, b1, busy1, done1, err1, fmask1} !== 11'b0) begin errors++; $display("FAIL reset dut1: got %b expected 0", {a1, b1, busy1, done1, err1, fmask1}); end
  endtask

  task automatic test_good();
    int cyc;
    fault_mode = 0;
    run0(0, cyc);
    check_result("good", cyc, 88, 3'd0, 4'b0000);
    checks++;
    if ({a, b, done} !== 3'b111) begin errors++; $display("FAIL good last_vec: got %b expected 111", {a, b, done}); end
  endtask

  task automatic test_and_as_or();
    int cyc;
    logic [2:0] e_err;
    logic [3:0] e_mask;
    fault_mode = 1;
    ref_sweep(1, e_err, e_mask);
    run0(0, cyc);
    check_result("and_as_or", cyc, 88, e_err, e_mask);
    checks++;
    if ({err, fmask} !== {3'd2, 4'b0110}) begin errors++; $display("FAIL and_as_or table: got %b expected 0100110", {err, fmask}); end
  endtask

  task automatic test_stuck0();
    int cyc;
    fault_mode = 2;
    run0(0, cyc);
    check_result("stuck0", cyc, 88, 3'd4, 4'b1111);
  endtask

  task automatic test_random();
    int cyc;
    logic [2:0] e_err;
    logic [3:0] e_mask;
    for (int t = 0; t < 6; t++) begin
      fault_mode = 3;
      for (int i = 0; i < 4; i++) xorv[i] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      ref_sweep(3, e_err, e_mask);
      run0(0, cyc);
      check_result("random", cyc, 88, e_err, e_mask);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fault_mode = 0;
    run0(int'($urandom_range(3, 80)), cyc);
    check_result("busy_start", cyc, 88, 3'd0, 4'b0000);
  endtask

  task automatic test_reset_mid();
    int cyc;
    fault_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 50) begin @(posedge clk); #1; cyc++; end
    checks++;
    if ({busy, err} !== {1'b1, 3'd2}) begin errors++; $display("FAIL mid_sweep: got %b expected 1010", {busy, err}); end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({a, b, busy, done, pass, err, fmask} !== 12'b0) begin errors++; $display("FAIL reset_mid: got %b expected 0", {a, b, busy, done, pass, err, fmask}); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy %b expected 0", busy); end
    fault_mode = 0;
    run0(0, cyc);
    check_result("after_reset", cyc, 88, 3'd0, 4'b0000);
  endtask

  task automatic test_glitch();
    int cyc;
    logic [3:0] m;
    logic [2:0] e_err;
    for (int t = 0; t < 5; t++) begin
      m = (t == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      e_err = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
      run1(m, cyc);
      checks++;
      if (cyc !== 12) begin errors++; $display("FAIL glitch len: got %0d expected 12", cyc); end
      checks++;
      if ({err1, fmask1} !== {e_err, m}) begin errors++; $display("FAIL glitch result: got %0d/%b expected %0d/%b", err1, fmask1, e_err, m); end
      checks++;
      if (pass1 !== (m == 4'b0000)) begin errors++; $display("FAIL glitch pass: got %b expected %b", pass1, m == 4'b0000); end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_and_as_or();
    test_back_to_back();
    test_stuck0();
    test_random();
    test_reset_mid();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
